// File: rtl/digit_overlay_renderer.sv
// On-screen number overlay: ready/valid capture, multi-cycle double-dabble BCD
// conversion, and a two-stage pixel pipeline drawing scaled 10x10 glyphs.

module digit_font_rom_10 (
    input  logic [3:0] i_code,
    input  logic [3:0] i_row,
    output logic [9:0] o_bits
);
    // Glyph rows are written as drawn: the leftmost character is screen column 0.
    localparam logic [9:0] FONT [0:10][0:9] = '{
        '{10'b0011111100, 10'b0110000110, 10'b0110001110, 10'b0110010110, 10'b0110100110,
          10'b0111000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        '{10'b0000110000, 10'b0011110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0011111100, 10'b0000000000},
        '{10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000001100, 10'b0000011000,
          10'b0000110000, 10'b0001100000, 10'b0011000000, 10'b0111111110, 10'b0000000000},
        '{10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000000110, 10'b0001111100,
          10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        '{10'b0000011100, 10'b0000111100, 10'b0001101100, 10'b0011001100, 10'b0110001100,
          10'b0111111110, 10'b0000001100, 10'b0000001100, 10'b0000001100, 10'b0000000000},
        '{10'b0111111110, 10'b0110000000, 10'b0110000000, 10'b0111111100, 10'b0000000110,
          10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        '{10'b0001111100, 10'b0011000000, 10'b0110000000, 10'b0111111100, 10'b0110000110,
          10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        '{10'b0111111110, 10'b0000000110, 10'b0000001100, 10'b0000011000, 10'b0000110000,
          10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0000000000},
        '{10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0110000110,
          10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        '{10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111110,
          10'b0000000110, 10'b0000000110, 10'b0000001100, 10'b0011111000, 10'b0000000000},
        '{10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0111111110,
          10'b0111111110, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000}
    };

    logic [9:0] w_visual;

    always_comb begin
        w_visual = '0;
        if (i_code <= 4'd10 && i_row <= 4'd9) begin
            w_visual = FONT[i_code][i_row];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_rev
            assign o_bits[gi] = w_visual[9 - gi];
        end
    endgenerate
endmodule

module digit_overlay_renderer #(
    parameter int PIXEL_WIDTH   = 12,
    parameter int PHY_WIDTH     = 14,
    parameter int VALUE_WIDTH   = 14,
    parameter int DIGITS        = 4,
    parameter int SIGNED_MODE   = 0,
    parameter int BLANK_LEADING = 1,
    parameter int ORIGIN_X      = 130,
    parameter int ORIGIN_Y      = 160,
    parameter int SCALE_SHIFT   = 3,
    parameter int DIGIT_PITCH   = 120,
    parameter logic [PIXEL_WIDTH-1:0] BG_COLOR  = 12'hFD8,
    parameter logic [PIXEL_WIDTH-1:0] FG_COLOR  = 12'hFFF,
    parameter logic [PIXEL_WIDTH-1:0] OFF_COLOR = 12'hFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   value_valid,
    output logic                   value_ready,
    input  logic [PHY_WIDTH-1:0]   map_x,
    input  logic [PHY_WIDTH-1:0]   map_y,
    input  logic                   map_on,
    output logic [PIXEL_WIDTH-1:0] rgb
);
    localparam int CELL  = 10 << SCALE_SHIFT;
    localparam int BCD_W = 4 * DIGITS;
    localparam int WRK_W = BCD_W + VALUE_WIDTH;
    localparam int CNT_W = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAXV = (SIGNED_MODE != 0) ? pow10(DIGITS - 1) - 1 : pow10(DIGITS) - 1;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t             r_state;
    logic               r_ready;
    logic [CNT_W-1:0]   r_iter;
    logic [WRK_W-1:0]   r_work;
    logic               r_neg;
    logic [BCD_W-1:0]   r_disp_bcd;
    logic               r_disp_neg;

    logic                   w_neg;
    logic [VALUE_WIDTH-1:0] w_mag_raw;
    logic [VALUE_WIDTH-1:0] w_mag;
    logic [BCD_W-1:0]       w_adj;

    always_comb begin
        w_neg     = (SIGNED_MODE != 0) && value_in[VALUE_WIDTH-1];
        w_mag_raw = w_neg ? (~value_in + 1'b1) : value_in;
        w_mag     = (longint'(w_mag_raw) > MAXV) ? VALUE_WIDTH'(MAXV) : w_mag_raw;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] w_nib;
            assign w_nib = r_work[VALUE_WIDTH + 4*gi +: 4];
            assign w_adj[4*gi +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_iter     <= '0;
            r_work     <= '0;
            r_neg      <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (value_valid && r_ready) begin
                        r_work  <= {{BCD_W{1'b0}}, w_mag};
                        r_neg   <= w_neg;
                        r_iter  <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_work <= {w_adj, r_work[VALUE_WIDTH-1:0]} << 1;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == CNT_W'(VALUE_WIDTH - 1)) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_disp_bcd <= r_work[WRK_W-1 -: BCD_W];
                    r_disp_neg <= r_neg;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign value_ready = r_ready;

    // Per-cell glyph code; spare entries beyond DIGITS read as blank.
    logic [3:0] w_code [8];
    generate
        for (gi = 0; gi < 8; gi++) begin : g_code
            if (gi >= DIGITS) begin : g_none
                assign w_code[gi] = 4'd15;
            end else if (SIGNED_MODE != 0 && gi == 0) begin : g_sign
                assign w_code[gi] = r_disp_neg ? 4'd10 : 4'd15;
            end else if (BLANK_LEADING != 0 && gi != DIGITS - 1) begin : g_blank
                localparam int D = DIGITS - 1 - gi;
                assign w_code[gi] = (r_disp_bcd[BCD_W-1:4*D] == '0) ? 4'd15 : r_disp_bcd[4*D +: 4];
            end else begin : g_plain
                localparam int D = DIGITS - 1 - gi;
                assign w_code[gi] = r_disp_bcd[4*D +: 4];
            end
        end
    endgenerate

    logic [PHY_WIDTH-1:0] w_dx;
    logic [PHY_WIDTH-1:0] w_dy;
    logic [DIGITS-1:0]    w_in_cell;
    logic [PHY_WIDTH-1:0] w_off [DIGITS];
    logic                 w_hit;
    logic [2:0]           w_cell;
    logic [3:0]           w_col;
    logic [3:0]           w_row;

    assign w_dx  = map_x - PHY_WIDTH'(ORIGIN_X);
    assign w_dy  = map_y - PHY_WIDTH'(ORIGIN_Y);
    assign w_row = 4'(w_dy >> SCALE_SHIFT);

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_cell
            localparam logic [PHY_WIDTH-1:0] LO = PHY_WIDTH'(gi * DIGIT_PITCH);
            localparam logic [PHY_WIDTH-1:0] HI = PHY_WIDTH'(gi * DIGIT_PITCH + CELL);
            if (gi == 0) begin : g_first
                assign w_in_cell[gi] = (w_dx < HI);
            end else begin : g_rest
                assign w_in_cell[gi] = (w_dx >= LO) && (w_dx < HI);
            end
            assign w_off[gi] = w_dx - LO;
        end
    endgenerate

    // Coordinates left of / above the origin wrap to large dx/dy but are rejected explicitly too.
    always_comb begin
        w_hit  = 1'b0;
        w_cell = '0;
        w_col  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_in_cell[k]) begin
                w_hit  = 1'b1;
                w_cell = 3'(k);
                w_col  = 4'(w_off[k] >> SCALE_SHIFT);
            end
        end
        if (map_x < PHY_WIDTH'(ORIGIN_X) || map_y < PHY_WIDTH'(ORIGIN_Y) || w_dy >= PHY_WIDTH'(CELL)) begin
            w_hit = 1'b0;
        end
    end

    logic       r_s1_hit;
    logic       r_s1_on;
    logic [2:0] r_s1_cell;
    logic [3:0] r_s1_row;
    logic [3:0] r_s1_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hit  <= 1'b0;
            r_s1_on   <= 1'b0;
            r_s1_cell <= '0;
            r_s1_row  <= '0;
            r_s1_col  <= '0;
        end else begin
            r_s1_hit  <= w_hit;
            r_s1_on   <= map_on;
            r_s1_cell <= w_cell;
            r_s1_row  <= w_row;
            r_s1_col  <= w_col;
        end
    end

    logic [9:0]             w_glyph_bits;
    logic [PIXEL_WIDTH-1:0] r_rgb;

    digit_font_rom_10 u_font (
        .i_code (w_code[r_s1_cell]),
        .i_row  (r_s1_row),
        .o_bits (w_glyph_bits)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (!r_s1_on) begin
            r_rgb <= OFF_COLOR;
        end else if (r_s1_hit && w_glyph_bits[r_s1_col]) begin
            r_rgb <= FG_COLOR;
        end else begin
            r_rgb <= BG_COLOR;
        end
    end

    assign rgb = r_rgb;
endmodule
